// File: rtl/demux_sched_pkg.sv
// ---------------------------------------------------------------------------
// demux_sched_pkg
// Shared definitions for the demux scheduler: the FSM state encoding, the
// fixed channel count, the select width and the slot counter width.
// No ports; imported by demux_sched and demux_sched_next.
// ---------------------------------------------------------------------------
package demux_sched_pkg;

    localparam int DS_CHANNELS  = 4;
    localparam int DS_SEL_WIDTH = 2;
    localparam int DS_CNT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SLOT = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/demux_sched_next.sv
// ---------------------------------------------------------------------------
// demux_sched_next
// Combinational next-channel finder for the demux scheduler.
// With start_i high it returns the lowest set bit of mask_i, as if the
// current index were -1. Otherwise it returns the lowest set bit strictly
// above cur_i. last_o is high when no such bit exists; next_o is then 0.
//   mask_i  : per-channel enable mask
//   cur_i   : channel index currently being played out
//   start_i : search from below channel 0 (used at word acceptance)
//   next_o  : next enabled channel index
//   last_o  : no further enabled channel exists
// ---------------------------------------------------------------------------
module demux_sched_next
    import demux_sched_pkg::*;
(
    input  logic [DS_CHANNELS-1:0]  mask_i,
    input  logic [DS_SEL_WIDTH-1:0] cur_i,
    input  logic                    start_i,
    output logic [DS_SEL_WIDTH-1:0] next_o,
    output logic                    last_o
);

    // Scan from the top down so that the lowest qualifying index is the one
    // left in next_o when the loop ends. The scan never wraps past index 3.
    always_comb begin
        next_o = '0;
        last_o = 1'b1;
        for (int i = DS_CHANNELS - 1; i >= 0; i--) begin
            if (mask_i[i] && (start_i || (i > int'(cur_i)))) begin
                next_o = DS_SEL_WIDTH'(i);
                last_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/demux_sched.sv
// ---------------------------------------------------------------------------
// demux_sched
// Upstream scheduler for a 1-to-4 demultiplexer. It accepts a 4-bit word and
// a channel mask over a valid/ready handshake. It then plays the word out one
// bit per enabled channel in ascending channel order, and holds each slot for
// SLOT_CYCLES clocks. All outputs are registered.
//   clk          : system clock, rising edge
//   rst_n        : synchronous active-low reset
//   word_in      : parallel data, bit i goes to channel i
//   chan_mask    : per-channel enable, bit i set = channel i gets a slot
//   word_valid   : upstream offers word_in/chan_mask
//   word_ready   : scheduler can accept a word
//   sched_in     : data bit for demux_in
//   sched_select : channel index for demux_select
//   sched_strobe : sched_in/sched_select form a valid slot
//   done         : one-cycle pulse after the last slot of a word
// Optional feature: define DEMUX_SCHED_GAP_EN to insert a one-cycle
// break-before-make gap between consecutive slots.
// ---------------------------------------------------------------------------
module demux_sched
    import demux_sched_pkg::*;
#(
    parameter int SLOT_CYCLES = 1,
    parameter int CHANNELS    = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DS_CHANNELS-1:0]  word_in,
    input  logic [DS_CHANNELS-1:0]  chan_mask,
    input  logic                    word_valid,
    output logic                    word_ready,
    output logic                    sched_in,
    output logic [DS_SEL_WIDTH-1:0] sched_select,
    output logic                    sched_strobe,
    output logic                    done
);

    localparam logic [DS_CNT_WIDTH-1:0] SLOT_LAST = DS_CNT_WIDTH'(SLOT_CYCLES - 1);

    if (SLOT_CYCLES < 1 || SLOT_CYCLES > 255) begin : gBadSlotCycles
        $error("demux_sched: SLOT_CYCLES must be in 1..255");
    end
    if (CHANNELS != DS_CHANNELS) begin : gBadChannels
        $error("demux_sched: CHANNELS is fixed at 4");
    end

    state_t                  state_q;
    logic [DS_CHANNELS-1:0]  word_q;
    logic [DS_CHANNELS-1:0]  mask_q;
    logic [DS_SEL_WIDTH-1:0] idx_q;
    logic [DS_CNT_WIDTH-1:0] cnt_q;
    logic [DS_CNT_WIDTH-1:0] cnt_d;
    logic                    ready_q;
    logic                    in_q;
    logic [DS_SEL_WIDTH-1:0] sel_q;
    logic                    strobe_q;
    logic                    done_q;

    logic [DS_CHANNELS-1:0]  finderMask;
    logic                    finderStart;
    logic [DS_SEL_WIDTH-1:0] nextIdx;
    logic                    nextLast;
    logic                    slotExpired;

    // A single finder instance serves two purposes. In IDLE it looks at the
    // live chan_mask from below channel 0 to pick the first slot of the word
    // being accepted. Everywhere else it walks the latched mask upward from
    // the current index.
    always_comb begin
        finderStart = (state_q == ST_IDLE);
        finderMask  = finderStart ? chan_mask : mask_q;
        cnt_d       = cnt_q + DS_CNT_WIDTH'(1);
        slotExpired = (cnt_q == SLOT_LAST);
    end

    demux_sched_next u_next (
        .mask_i  (finderMask),
        .cur_i   (idx_q),
        .start_i (finderStart),
        .next_o  (nextIdx),
        .last_o  (nextLast)
    );

    // Scheduler FSM with registered outputs. After reset word_ready is low.
    // The first IDLE cycle with rst_n high raises it, and word_valid is only
    // honoured while word_ready is already high. sched_select is left alone
    // in IDLE and DONE so that it keeps the last channel that was driven.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            word_q   <= '0;
            mask_q   <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            in_q     <= 1'b0;
            sel_q    <= '0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    strobe_q <= 1'b0;
                    in_q     <= 1'b0;
                    done_q   <= 1'b0;
                    if (ready_q && word_valid) begin
                        word_q  <= word_in;
                        mask_q  <= chan_mask;
                        ready_q <= 1'b0;
                        cnt_q   <= '0;
                        if (!nextLast) begin
                            state_q  <= ST_SLOT;
                            idx_q    <= nextIdx;
                            sel_q    <= nextIdx;
                            in_q     <= word_in[nextIdx];
                            strobe_q <= 1'b1;
                        end else begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        ready_q <= 1'b1;
                    end
                end

                ST_SLOT: begin
                    if (!slotExpired) begin
                        cnt_q <= cnt_d;
                    end else begin
                        cnt_q <= '0;
                        if (!nextLast) begin
                            idx_q <= nextIdx;
                            sel_q <= nextIdx;
`ifdef DEMUX_SCHED_GAP_EN
                            state_q  <= ST_GAP;
                            strobe_q <= 1'b0;
                            in_q     <= 1'b0;
`else
                            in_q     <= word_q[nextIdx];
`endif
                        end else begin
                            state_q  <= ST_DONE;
                            strobe_q <= 1'b0;
                            in_q     <= 1'b0;
                            done_q   <= 1'b1;
                        end
                    end
                end

`ifdef DEMUX_SCHED_GAP_EN
                ST_GAP: begin
                    state_q  <= ST_SLOT;
                    strobe_q <= 1'b1;
                    in_q     <= word_q[idx_q];
                end
`endif

                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                end

                default: begin
                    state_q  <= ST_IDLE;
                    strobe_q <= 1'b0;
                    in_q     <= 1'b0;
                    done_q   <= 1'b0;
                    ready_q  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        word_ready   = ready_q;
        sched_in     = in_q;
        sched_select = sel_q;
        sched_strobe = strobe_q;
        done         = done_q;
    end

endmodule
